// File: rtl/sd_regs_pkg.sv
// Shared definitions for the SD host register responder: FSM states,
// rw encodings and the location of the read-only status register.
package sd_regs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // The topmost implemented register mirrors the SD core status word.
    function automatic int ro_addr(input int reg_witdh);
        return reg_witdh - 1;
    endfunction

endpackage

// File: rtl/sd_reg_responder_if.sv
// Host-side request/response bus of the SD register responder.
interface sd_reg_responder_if #(
    parameter int data_witdh = 32,
    parameter int addr_witdh = 5
);
    logic                  req;
    logic                  rw;
    logic [addr_witdh-1:0] addr;
    logic [data_witdh-1:0] data_in;
    logic [data_witdh-1:0] data_out;
    logic                  ack;
    logic                  err;

    modport master (output req, rw, addr, data_in, input data_out, ack, err);
    modport slave  (input req, rw, addr, data_in, output data_out, ack, err);
endinterface

// File: rtl/sd_reg_storage.sv
// Resettable register bank with one write port, one combinational read
// port and a flat view of every register for the SD host core.
module sd_reg_storage
    import sd_regs_pkg::*;
#(
    parameter int data_witdh = 32,
    parameter int addr_witdh = 5,
    parameter int reg_witdh  = 28
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            we,
    input  logic [addr_witdh-1:0]           waddr,
    input  logic [data_witdh-1:0]           wdata,
    input  logic [addr_witdh-1:0]           raddr,
    output logic [data_witdh-1:0]           rdata,
    output logic [reg_witdh*data_witdh-1:0] regs_out
);
    localparam logic [addr_witdh:0] REG_CNT = (addr_witdh+1)'(reg_witdh);

    logic [data_witdh-1:0] words [reg_witdh];

    // Flip-flops rather than RAM: the whole bank must clear on reset and
    // be visible in parallel on regs_out.
    generate
        for (genvar gi = 0; gi < reg_witdh; gi++) begin : g_reg
            localparam logic [addr_witdh-1:0] IDX = addr_witdh'(gi);
            logic [data_witdh-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (we && (waddr == IDX)) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
            assign regs_out[gi*data_witdh +: data_witdh] = word_reg;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        if ({1'b0, raddr} < REG_CNT) begin
            rdata = words[raddr];
        end
    end

endmodule

// File: rtl/sd_reg_responder.sv
// SD host register responder: three-state IDLE/EXEC/ACK handshake that
// writes/reads the register bank and flags unmapped or read-only accesses.
module sd_reg_responder
    import sd_regs_pkg::*;
#(
    parameter int data_witdh = 32,
    parameter int addr_witdh = 5,
    parameter int reg_witdh  = 28
) (
    input  logic                            clk,
    input  logic                            reset,
    sd_reg_responder_if.slave               bus,
    input  logic [data_witdh-1:0]           status_in,
    output logic [reg_witdh*data_witdh-1:0] regs_out
);
    localparam logic [addr_witdh:0]   REG_CNT = (addr_witdh+1)'(reg_witdh);
    localparam logic [addr_witdh-1:0] RO_ADDR = addr_witdh'(ro_addr(reg_witdh));

    state_t                state_reg;
    logic                  rw_reg;
    logic [addr_witdh-1:0] addr_reg;
    logic [data_witdh-1:0] data_reg;
    logic [data_witdh-1:0] data_out_reg;
    logic                  ack_reg;
    logic                  err_reg;

    logic                  mapped;
    logic                  is_ro;
    logic                  wr_en;
    logic [data_witdh-1:0] rd_word;

    assign mapped = ({1'b0, addr_reg} < REG_CNT);
    assign is_ro  = (addr_reg == RO_ADDR);
    assign wr_en  = (state_reg == EXEC) && (rw_reg == RW_WRITE) && mapped && !is_ro;

    sd_reg_storage #(
        .data_witdh (data_witdh),
        .addr_witdh (addr_witdh),
        .reg_witdh  (reg_witdh)
    ) u_storage (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .waddr    (addr_reg),
        .wdata    (data_reg),
        .raddr    (addr_reg),
        .rdata    (rd_word),
        .regs_out (regs_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            rw_reg       <= RW_WRITE;
            addr_reg     <= '0;
            data_reg     <= '0;
            data_out_reg <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        rw_reg    <= bus.rw;
                        addr_reg  <= bus.addr;
                        data_reg  <= bus.data_in;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    ack_reg <= 1'b1;
                    err_reg <= !mapped || ((rw_reg == RW_WRITE) && is_ro);
                    // data_out only moves on reads; writes leave it untouched.
                    if (rw_reg == RW_READ) begin
                        if (!mapped)    data_out_reg <= '0;
                        else if (is_ro) data_out_reg <= status_in;
                        else            data_out_reg <= rd_word;
                    end
                    state_reg <= ACK;
                end
                ACK: begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.ack      = ack_reg;
    assign bus.err      = err_reg;

endmodule
